// File: rtl/led_bound_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_bound_sequencer_pkg
//  Description : Shared types and constants for the LED bound sequencer:
//                FSM state enum, bar geometry, reset waypoint table and the
//                levels at which a kickback request is honoured.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_bound_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    localparam int LED_MAX = 16;
    localparam int LEVEL_W = 5;

    // Waypoint table contents after reset
    localparam logic [LEVEL_W-1:0] WP_RST_0 = 5'd16;
    localparam logic [LEVEL_W-1:0] WP_RST_1 = 5'd5;
    localparam logic [LEVEL_W-1:0] WP_RST_2 = 5'd11;
    localparam logic [LEVEL_W-1:0] WP_RST_3 = 5'd0;
    localparam logic [LEVEL_W-1:0] WP_RST_4 = 5'd6;
    localparam logic [LEVEL_W-1:0] WP_RST_5 = 5'd0;

    // Levels at which a start during a descent bounces the bar back up
    localparam logic [LEVEL_W-1:0] KICK_LVL_LO = 5'd0;
    localparam logic [LEVEL_W-1:0] KICK_LVL_HI = 5'd5;

    function automatic logic [LEVEL_W-1:0] wp_reset_value(input logic [2:0] idx);
        logic [LEVEL_W-1:0] val;
        case (idx)
            3'd0:    val = WP_RST_0;
            3'd1:    val = WP_RST_1;
            3'd2:    val = WP_RST_2;
            3'd3:    val = WP_RST_3;
            3'd4:    val = WP_RST_4;
            default: val = WP_RST_5;
        endcase
        return val;
    endfunction

    // Saturate a written target to the bar length
    function automatic logic [LEVEL_W-1:0] clamp_level(input logic [LEVEL_W-1:0] d);
        return (d > LEVEL_W'(LED_MAX)) ? LEVEL_W'(LED_MAX) : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_thermo_enc.sv
`default_nettype none
// ============================================================================
//  Module      : led_thermo_enc
//  Description : Converts a bar level 0..16 into a 16-bit thermometer code,
//                bits [level-1:0] set. Purely combinational.
//  Ports       : level (in, 5)  - bar length
//                led   (out,16) - thermometer code
//  Revision    : 1.0 - initial release
// ============================================================================
module led_thermo_enc
    import led_bound_sequencer_pkg::*;
(
    input  logic [LEVEL_W-1:0] level,
    output logic [LED_MAX-1:0] led
);

    for (genvar i = 0; i < LED_MAX; i++) begin : g_bit
        assign led[i] = (level > LEVEL_W'(i));
    end

endmodule
`default_nettype wire

// File: rtl/led_bound_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : led_bound_sequencer
//  Description : Walks an LED bar through a programmable table of waypoint
//                levels, one step per TICK_DIV clocks, dwelling one tick at
//                each waypoint. A start while descending at level 0 or 5
//                kicks the bar back toward the previous waypoint.
//  Ports       : clk, rst_n (async, active-low)
//                start              - begin a sequence / kickback request
//                cfg_we/addr/data   - waypoint table write (idle only)
//                busy, done         - sequence running / completion pulse
//                level, led         - bar length and its thermometer code
//  Revision    : 1.0 - initial release
// ============================================================================
module led_bound_sequencer
    import led_bound_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 1,
    parameter int NUM_WP   = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [4:0]  cfg_data,
    output logic        busy,
    output logic        done,
    output logic [4:0]  level,
    output logic [15:0] led
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
    localparam logic [2:0]  LAST_IDX  = 3'(NUM_WP - 1);

    state_t             r_state, w_state_nxt;
    logic [2:0]         r_idx, w_idx_nxt;
    logic [LEVEL_W-1:0] r_level, w_level_nxt;
    logic [15:0]        r_tick, w_tick_nxt;
    logic               r_done, w_done_nxt;
    logic [LEVEL_W-1:0] r_wp [NUM_WP];

    logic               w_step;
    logic               w_kick;
    logic               w_cfg_wr;
    logic [LEVEL_W-1:0] w_target;

    // Table is only writable while idle so a running sequence never sees
    // its waypoints change underneath it.
    assign w_cfg_wr = cfg_we && (r_state == IDLE) && (cfg_addr <= LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WP; i++) begin
                r_wp[i] <= wp_reset_value(3'(i));
            end
        end else if (w_cfg_wr) begin
            r_wp[cfg_addr] <= clamp_level(cfg_data);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_level <= '0;
            r_tick  <= 16'd0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_level <= w_level_nxt;
            r_tick  <= w_tick_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_level_nxt = r_level;
        w_tick_nxt  = r_tick;
        w_done_nxt  = 1'b0;
        w_target    = r_wp[r_idx];
        w_step      = (r_state != IDLE) && (r_tick == TICK_LAST);
        w_kick      = start && (r_state == DOWN)
                      && ((r_level == KICK_LVL_LO) || (r_level == KICK_LVL_HI))
                      && (r_idx != LAST_IDX) && (r_idx != 3'd0);

        case (r_state)
            IDLE: begin
                w_tick_nxt = 16'd0;
                if (start) begin
                    w_state_nxt = UP;
                    w_idx_nxt   = 3'd0;
                    w_level_nxt = '0;
                end
            end
            default: begin
                // Kickback takes priority over a coincident step tick
                if (w_kick) begin
                    w_state_nxt = UP;
                    w_idx_nxt   = r_idx - 3'd1;
                    w_level_nxt = r_level + 5'd1;
                    w_tick_nxt  = 16'd0;
                end else begin
                    w_tick_nxt = w_step ? 16'd0 : r_tick + 16'd1;
                    if (w_step) begin
                        if (r_level < w_target) begin
                            w_level_nxt = r_level + 5'd1;
                        end else if (r_level > w_target) begin
                            w_level_nxt = r_level - 5'd1;
                        end else if (r_idx != LAST_IDX) begin
                            // Arrival tick is spent as a dwell; the level
                            // holds while the next waypoint is selected.
                            w_idx_nxt   = r_idx + 3'd1;
                            w_state_nxt = (r_wp[r_idx + 3'd1] > r_level) ? UP : DOWN;
                        end else begin
                            w_state_nxt = IDLE;
                            w_idx_nxt   = 3'd0;
                            w_level_nxt = '0;
                            w_tick_nxt  = 16'd0;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    assign busy  = (r_state != IDLE);
    assign done  = r_done;
    assign level = r_level;

    led_thermo_enc u_thermo (
        .level (r_level),
        .led   (led)
    );

endmodule
`default_nettype wire

// File: tb/tb_led_bound_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_bound_sequencer
//  Description : Drives two sequencers (TICK_DIV 1 and 4) with shared stimulus
//                and compares both against a behavioural model every cycle,
//                plus directed scenarios with hand-computed expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_led_bound_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [4:0]  cfg_data;
    logic        busy0, done0, busy1, done1;
    logic [4:0]  level0, level1;
    logic [15:0] led0, led1;

    always #5 clk = ~clk;

    led_bound_sequencer #(.TICK_DIV(1), .NUM_WP(6)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy0), .done(done0), .level(level0), .led(led0)
    );

    led_bound_sequencer #(.TICK_DIV(4), .NUM_WP(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_we(cfg_we),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy1), .done(done1), .level(level1), .led(led1)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void check(string name, int actual, int expected);
        n_checks++;
        if (actual != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    int td [2]         = '{1, 4};
    int wp_default [6] = '{16, 5, 11, 0, 6, 0};
    int m_busy [2], m_done [2], m_level [2], m_idx [2], m_phase [2], m_down [2];
    int m_wp [2][6];
    int tgt;
    bit kick, tick;

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 0; m_done[k] = 0; m_level[k] = 0;
                m_idx[k] = 0; m_phase[k] = 0; m_down[k] = 0;
                for (int i = 0; i < 6; i++) m_wp[k][i] = wp_default[i];
            end else if (m_busy[k] == 0) begin
                m_done[k] = 0;
                if (cfg_we === 1'b1 && int'(cfg_addr) < 6)
                    m_wp[k][cfg_addr] = (int'(cfg_data) > 16) ? 16 : int'(cfg_data);
                if (start === 1'b1) begin
                    m_busy[k] = 1; m_idx[k] = 0; m_level[k] = 0;
                    m_phase[k] = 0; m_down[k] = 0;
                end
            end else begin
                m_done[k] = 0;
                kick = (start === 1'b1) && m_down[k] == 1
                       && (m_level[k] == 0 || m_level[k] == 5)
                       && m_idx[k] >= 1 && m_idx[k] != 5;
                if (kick) begin
                    m_idx[k]   = m_idx[k] - 1;
                    m_down[k]  = 0;
                    m_level[k] = m_level[k] + 1;
                    m_phase[k] = 0;
                end else begin
                    tick       = (m_phase[k] == td[k] - 1);
                    m_phase[k] = (m_phase[k] + 1) % td[k];
                    if (tick) begin
                        tgt = m_wp[k][m_idx[k]];
                        if (m_level[k] != tgt) begin
                            m_level[k] = m_level[k] + ((tgt > m_level[k]) ? 1 : -1);
                        end else if (m_idx[k] < 5) begin
                            m_idx[k]  = m_idx[k] + 1;
                            m_down[k] = (m_wp[k][m_idx[k]] > m_level[k]) ? 0 : 1;
                        end else begin
                            m_busy[k] = 0; m_level[k] = 0; m_done[k] = 1;
                        end
                    end
                end
            end
        end
    end

    function automatic void cmp(int k, logic b, logic d, logic [4:0] l, logic [15:0] ld);
        int exp_led;
        exp_led = (1 << m_level[k]) - 1;
        n_checks++;
        if (b !== 1'(m_busy[k]) || d !== 1'(m_done[k]) || l !== 5'(m_level[k])
            || ld !== exp_led[15:0]) begin
            n_errors++;
            $display("FAIL model dut%0d @%0t: busy=%b/%0d done=%b/%0d level=%0d/%0d led=%h/%h",
                     k, $time, b, m_busy[k], d, m_done[k], l, m_level[k], ld, exp_led[15:0]);
        end
    endfunction

    // Per-sequence statistics collected at the sampling edge
    int bc0, bc1, dc0, dc1, mx0;

    always @(negedge clk) begin
        cmp(0, busy0, done0, level0, led0);
        cmp(1, busy1, done1, level1, led1);
        if (busy0) bc0++;
        if (busy1) bc1++;
        if (done0) dc0++;
        if (done1) dc1++;
        if (int'(level0) > mx0) mx0 = int'(level0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_stats();
        bc0 = 0; bc1 = 0; dc0 = 0; dc1 = 0; mx0 = 0;
    endtask

    task automatic start_seq();
        clear_stats();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy0 || busy1) && n < 600) begin
            step(1);
            n++;
        end
        check("idle_reached", int'(busy0 | busy1), 0);
        step(2);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 5'd0;
        step(3);
        check("rst_level", int'(level0), 0);
        check("rst_led", int'(led0), 0);
        check("rst_busy", int'(busy0), 0);
        check("rst_done", int'(done0), 0);
        rst_n = 1'b1;
        step(1);

        // Default table trajectory
        start_seq();
        step(16);
        check("trace_peak", int'(level0), 16);
        wait_idle();
        check("trace_len_td1", bc0, 62);
        check("trace_done_td1", dc0, 1);
        check("trace_len_td4", bc1, 248);
        check("trace_done_td4", dc1, 1);
        check("trace_max", mx0, 16);

        // Kickback from level 5 at waypoint 1
        start_seq();
        step(28);
        check("kick_pre", int'(level0), 5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("kick_level", int'(level0), 6);
        check("kick_led", int'(led0), 16'h003F);
        step(10);
        check("kick_climb", int'(level0), 16);
        wait_idle();

        // Ignored start while rising, ignored write while busy
        start_seq();
        step(8);
        check("ign_pre", int'(level0), 8);
        start = 1'b1;
        step(1);
        start = 1'b0;
        check("ign_level", int'(level0), 9);
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 5'd0;
        step(1);
        cfg_we = 1'b0;
        wait_idle();
        check("ign_len_td1", bc0, 62);
        check("ign_len_td4", bc1, 248);
        start_seq();
        wait_idle();
        check("readback_len_td1", bc0, 62);
        check("readback_len_td4", bc1, 248);

        // All-3 table
        for (int a = 0; a < 6; a++) begin
            cfg_we = 1'b1; cfg_addr = 3'(a); cfg_data = 5'd3;
            step(1);
        end
        cfg_we = 1'b0;
        start_seq();
        wait_idle();
        check("flat_len_td1", bc0, 9);
        check("flat_max", mx0, 3);
        check("flat_len_td4", bc1, 36);

        // Oversized write coinciding with start
        clear_stats();
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 5'd20; start = 1'b1;
        step(1);
        cfg_we = 1'b0; start = 1'b0;
        wait_idle();
        check("clamp_len_td1", bc0, 35);
        check("clamp_max", mx0, 16);
        check("clamp_len_td4", bc1, 140);

        // Reset mid-descent
        start_seq();
        step(20);
        check("rst_mid_pre", int'(level0), 13);
        rst_n = 1'b0;
        #1;
        check("rst_mid_level", int'(level0), 0);
        check("rst_mid_led", int'(led0), 0);
        check("rst_mid_busy", int'(busy0), 0);
        check("rst_mid_done", int'(done0), 0);
        step(1);
        clear_stats();
        rst_n = 1'b1; start = 1'b1;
        step(1);
        start = 1'b0;
        check("rst_restart_busy", int'(busy0), 1);
        wait_idle();
        check("rst_restart_len", bc0, 62);
        check("rst_restart_done", dc0, 1);
        check("rst_restart_len4", bc1, 248);

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            start    = ($urandom_range(0, 7) == 0);
            cfg_we   = ($urandom_range(0, 3) == 0);
            cfg_addr = 3'($urandom_range(0, 7));
            cfg_data = 5'($urandom_range(0, 31));
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            step(1);
        end
        start = 1'b0; cfg_we = 1'b0; rst_n = 1'b1;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
